// File: rtl/pc_sequencer_if.sv
// Bundles the debug, hazard/branch and PC-register signals around the fetch-stage sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int CYCLE_CNT_WIDTH = 32
);
  logic                       i_run;
  logic                       i_step;
  logic                       i_halt_instr;
  logic                       i_stall;
  logic                       i_branch_taken;
  logic [DATA_WIDTH-1:0]      i_branch_target;
  logic                       i_jump;
  logic [DATA_WIDTH-1:0]      i_jump_target;
  logic [DATA_WIDTH-1:0]      i_pc;
  logic [DATA_WIDTH-1:0]      o_pc_next;
  logic                       o_pc_enable;
  logic [1:0]                 o_state;
  logic                       o_halted;
  logic [CYCLE_CNT_WIDTH-1:0] o_cycle_count;

  modport master (
    output i_run, i_step, i_halt_instr, i_stall, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_pc,
    input  o_pc_next, o_pc_enable, o_state, o_halted, o_cycle_count
  );

  modport slave (
    input  i_run, i_step, i_halt_instr, i_stall, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_pc,
    output o_pc_next, o_pc_enable, o_state, o_halted, o_cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage execution controller: debug-driven run/step/halt FSM that selects the next PC
// and produces the pipeline-advance enable, plus a saturating count of active cycles.
module pc_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int PC_STEP         = 4,
  parameter int CYCLE_CNT_WIDTH = 32
) (
  input logic          i_clock,
  input logic          i_reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       halted;
  logic [CYCLE_CNT_WIDTH-1:0] cycle_count;
  logic                       active;
  logic                       eligible;
  logic                       advance;
  logic [DATA_WIDTH-1:0]      pc_next;

  assign active   = (state == RUN) || (state == STEP);
  assign eligible = active && !bus.i_stall;
  assign advance  = eligible && !bus.i_halt_instr;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.i_run)       state_next = RUN;
        else if (bus.i_step) state_next = STEP;
      end
      RUN: begin
        if (eligible && bus.i_halt_instr) state_next = HALTED;
      end
      STEP: begin
        // A stalled step waits; the first unstalled cycle is its single advance.
        if (eligible) state_next = bus.i_halt_instr ? HALTED : IDLE;
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cycle_count <= '0;
    end else if (active && (cycle_count != {CYCLE_CNT_WIDTH{1'b1}})) begin
      cycle_count <= cycle_count + CYCLE_CNT_WIDTH'(1);
    end
  end

  // The branch is the older instruction in the pipe, so it outranks a younger jump.
  always_comb begin
    pc_next = bus.i_pc;
    if (advance) begin
      if (bus.i_branch_taken)  pc_next = bus.i_branch_target;
      else if (bus.i_jump)     pc_next = bus.i_jump_target;
      else                     pc_next = bus.i_pc + DATA_WIDTH'(PC_STEP);
    end
  end

  assign bus.o_pc_next     = pc_next;
  assign bus.o_pc_enable   = advance;
  assign bus.o_state       = state;
  assign bus.o_halted      = halted;
  assign bus.o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized cycles compared
// against a behavioural model; the bench plays the PC register by feeding o_pc_next back.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.DATA_WIDTH(32), .CYCLE_CNT_WIDTH(32)) bus ();
  pc_sequencer_if #(.DATA_WIDTH(32), .CYCLE_CNT_WIDTH(4))  sbus ();

  pc_sequencer #(.DATA_WIDTH(32), .PC_STEP(4), .CYCLE_CNT_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus)
  );

  pc_sequencer #(.DATA_WIDTH(32), .PC_STEP(4), .CYCLE_CNT_WIDTH(4)) dut_sat (
    .i_clock(clk), .i_reset(rst_n), .bus(sbus)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: mode 0 idle, 1 running, 2 stepping, 3 halted (matches the o_state codes).
  int          mstate = 0;
  logic [31:0] mcount = 0;
  logic [31:0] pc     = 0;

  function automatic bit m_adv();
    return (mstate == 1 || mstate == 2) && !bus.i_stall && !bus.i_halt_instr;
  endfunction

  function automatic logic [31:0] m_pc_next();
    if (!m_adv())               return pc;
    if (bus.i_branch_taken)     return bus.i_branch_target;
    if (bus.i_jump)             return bus.i_jump_target;
    return pc + 32'd4;
  endfunction

  function automatic int m_next_state();
    case (mstate)
      0: return bus.i_run ? 1 : (bus.i_step ? 2 : 0);
      1: return (!bus.i_stall && bus.i_halt_instr) ? 3 : 1;
      2: return bus.i_stall ? 2 : (bus.i_halt_instr ? 3 : 0);
      default: return 3;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.i_run = 0; bus.i_step = 0; bus.i_halt_instr = 0; bus.i_stall = 0;
    bus.i_branch_taken = 0; bus.i_branch_target = 0; bus.i_jump = 0; bus.i_jump_target = 0;
    bus.i_pc = pc;
  endtask

  // One clock: advance the model using the inputs present before the edge.
  task automatic tick();
    int          nstate;
    logic [31:0] npc;
    nstate = m_next_state();
    npc    = m_pc_next();
    @(posedge clk);
    #1;
    if ((mstate == 1 || mstate == 2) && mcount != 32'hFFFF_FFFF) mcount = mcount + 1;
    mstate = nstate;
    pc     = npc;
    bus.i_pc = pc;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    mstate = 0;
    mcount = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] pc0);
    pc = pc0;
    do_reset();
    bus.i_run = 1;
    tick();
    bus.i_run = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    bus.i_pc = 32'h0000_1234; bus.i_run = 1; bus.i_jump = 1; bus.i_jump_target = 32'h40;
    #1;
    checks++; if (bus.o_pc_enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %0b expected 0", bus.o_pc_enable); end
    checks++; if (bus.o_pc_next !== 32'h1234) begin fails++; $display("FAIL reset_pc_next: got %0h expected 1234", bus.o_pc_next); end
    checks++; if (bus.o_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0b expected 00", bus.o_state); end
    checks++; if (bus.o_cycle_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.o_cycle_count); end
    checks++; if (bus.o_halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %0b expected 0", bus.o_halted); end
    rst_n = 1;
    pc = 0;
    do_reset();
  endtask

  task automatic test_run_sequential();
    start_run(32'h0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (bus.o_pc_next !== 32'(4 * i)) begin fails++; $display("FAIL run_pc_next[%0d]: got %0h expected %0h", i, bus.o_pc_next, 4 * i); end
      checks++; if (bus.o_pc_enable !== 1'b1) begin fails++; $display("FAIL run_enable[%0d]: got %0b expected 1", i, bus.o_pc_enable); end
      checks++; if (bus.o_state !== 2'b01) begin fails++; $display("FAIL run_state[%0d]: got %0b expected 01", i, bus.o_state); end
      tick();
    end
    checks++; if (bus.o_cycle_count !== 32'd3) begin fails++; $display("FAIL run_count: got %0d expected 3", bus.o_cycle_count); end
  endtask

  task automatic test_stall();
    start_run(32'h10);
    bus.i_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.o_pc_next !== 32'h10) begin fails++; $display("FAIL stall_pc_next[%0d]: got %0h expected 10", i, bus.o_pc_next); end
      checks++; if (bus.o_pc_enable !== 1'b0) begin fails++; $display("FAIL stall_enable[%0d]: got %0b expected 0", i, bus.o_pc_enable); end
      tick();
    end
    checks++; if (bus.o_cycle_count !== 32'd2) begin fails++; $display("FAIL stall_count: got %0d expected 2", bus.o_cycle_count); end
    bus.i_stall = 0;
    #1;
    checks++; if (bus.o_pc_next !== 32'h14) begin fails++; $display("FAIL stall_release: got %0h expected 14", bus.o_pc_next); end
    tick();
  endtask

  task automatic test_redirect();
    start_run(32'h100);
    bus.i_branch_taken = 1; bus.i_branch_target = 32'h80;
    bus.i_jump = 1;         bus.i_jump_target   = 32'h40;
    #1;
    checks++; if (bus.o_pc_next !== 32'h80) begin fails++; $display("FAIL branch_over_jump: got %0h expected 80", bus.o_pc_next); end
    tick();
    bus.i_branch_taken = 0;
    #1;
    checks++; if (bus.o_pc_next !== 32'h40) begin fails++; $display("FAIL jump_alone: got %0h expected 40", bus.o_pc_next); end
    tick();
    bus.i_jump = 0;
  endtask

  task automatic test_step();
    pc = 32'h200;
    do_reset();
    bus.i_step = 1;
    tick();
    bus.i_step = 0;
    bus.i_stall = 1;
    #1;
    checks++; if (bus.o_state !== 2'b10 || bus.o_pc_enable !== 1'b0) begin fails++; $display("FAIL step_stalled: got state %0b en %0b expected 10/0", bus.o_state, bus.o_pc_enable); end
    tick();
    bus.i_stall = 0;
    #1;
    checks++; if (bus.o_state !== 2'b10) begin fails++; $display("FAIL step_still_step: got %0b expected 10", bus.o_state); end
    checks++; if (bus.o_pc_next !== 32'h204 || bus.o_pc_enable !== 1'b1) begin fails++; $display("FAIL step_advance: got %0h en %0b expected 204/1", bus.o_pc_next, bus.o_pc_enable); end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.o_state !== 2'b00 || bus.o_pc_next !== 32'h204 || bus.o_pc_enable !== 1'b0) begin fails++; $display("FAIL step_hold[%0d]: got state %0b pc %0h en %0b expected 00/204/0", i, bus.o_state, bus.o_pc_next, bus.o_pc_enable); end
      tick();
    end
    checks++; if (bus.o_cycle_count !== 32'd2) begin fails++; $display("FAIL step_count: got %0d expected 2", bus.o_cycle_count); end
  endtask

  task automatic test_halt();
    start_run(32'h20);
    tick();
    bus.i_halt_instr = 1;
    #1;
    checks++; if (bus.o_pc_enable !== 1'b0 || bus.o_pc_next !== 32'h24) begin fails++; $display("FAIL halt_hold: got pc %0h en %0b expected 24/0", bus.o_pc_next, bus.o_pc_enable); end
    tick();
    checks++; if (bus.o_state !== 2'b11 || bus.o_halted !== 1'b1) begin fails++; $display("FAIL halt_state: got %0b halted %0b expected 11/1", bus.o_state, bus.o_halted); end
    bus.i_run = 1; bus.i_step = 1;
    tick();
    bus.i_run = 0; bus.i_step = 0;
    tick();
    checks++; if (bus.o_state !== 2'b11 || bus.o_pc_next !== 32'h24 || bus.o_pc_enable !== 1'b0) begin fails++; $display("FAIL halt_terminal: got state %0b pc %0h en %0b expected 11/24/0", bus.o_state, bus.o_pc_next, bus.o_pc_enable); end
    checks++; if (bus.o_cycle_count !== 32'd2) begin fails++; $display("FAIL halt_count: got %0d expected 2", bus.o_cycle_count); end
  endtask

  task automatic test_wrap_and_async_reset();
    start_run(32'hFFFF_FFFC);
    #1;
    checks++; if (bus.o_pc_next !== 32'h0 || bus.o_pc_enable !== 1'b1) begin fails++; $display("FAIL pc_wrap: got %0h en %0b expected 0/1", bus.o_pc_next, bus.o_pc_enable); end
    tick(); tick(); tick();
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (bus.o_state !== 2'b00 || bus.o_cycle_count !== 32'd0) begin fails++; $display("FAIL async_reset: got state %0b count %0d expected 00/0", bus.o_state, bus.o_cycle_count); end
    rst_n = 1;
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    sbus.i_stall = 1;
    sbus.i_run = 1;
    @(posedge clk); #1;
    sbus.i_run = 0;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (sbus.o_cycle_count !== 4'd14) begin fails++; $display("FAIL sat_count_14: got %0d expected 14", sbus.o_cycle_count); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (sbus.o_cycle_count !== 4'hF) begin fails++; $display("FAIL sat_count_hold: got %0d expected 15", sbus.o_cycle_count); end
    sbus.i_stall = 0;
  endtask

  task automatic test_random();
    pc = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 75 == 74) do_reset();
      bus.i_run           = ($urandom % 6) == 0;
      bus.i_step          = ($urandom % 6) == 0;
      bus.i_stall         = ($urandom % 4) == 0;
      bus.i_halt_instr    = ($urandom % 20) == 0;
      bus.i_branch_taken  = ($urandom % 5) == 0;
      bus.i_branch_target = $urandom & 32'hFFFF_FFFC;
      bus.i_jump          = ($urandom % 5) == 0;
      bus.i_jump_target   = $urandom & 32'hFFFF_FFFC;
      #1;
      checks++;
      if (bus.o_pc_next !== m_pc_next() || bus.o_pc_enable !== m_adv() ||
          bus.o_state !== 2'(mstate) || bus.o_halted !== (mstate == 3) ||
          bus.o_cycle_count !== mcount) begin
        fails++;
        $display("FAIL random[%0d]: got pc %0h en %0b st %0d hl %0b cnt %0d expected pc %0h en %0b st %0d hl %0b cnt %0d",
                 cyc, bus.o_pc_next, bus.o_pc_enable, bus.o_state, bus.o_halted, bus.o_cycle_count,
                 m_pc_next(), m_adv(), mstate, (mstate == 3), mcount);
      end
      tick();
    end
  endtask

  initial begin
    sbus.i_run = 0; sbus.i_step = 0; sbus.i_halt_instr = 0; sbus.i_stall = 0;
    sbus.i_branch_taken = 0; sbus.i_branch_target = 0; sbus.i_jump = 0;
    sbus.i_jump_target = 0; sbus.i_pc = 0;
    clear_inputs();
    test_reset();
    test_run_sequential();
    test_stall();
    test_redirect();
    test_step();
    test_halt();
    test_wrap_and_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
